// File: rtl/menu_ctrl_pkg.sv
// Shared definitions for the OSD menu: FSM states, item and button numbering,
// and the 5-digit BCD step helpers used by the editor.
package menu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HIDDEN = 2'd0,
        ST_NAV    = 2'd1,
        ST_EDIT   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    localparam int ITEM_MODE = 0;
    localparam int ITEM_AGC  = 1;
    localparam int ITEM_LVL1 = 2;
    localparam int ITEM_LVL2 = 3;
    localparam int ITEM_TINT = 4;
    localparam int NUM_ITEMS = 5;

    localparam int BTN_UP   = 0;
    localparam int BTN_DOWN = 1;
    localparam int BTN_SEL  = 2;
    localparam int NUM_BTNS = 3;

    // Ripple a +1 through the digits; a 9 rolls to 0 and carries on.
    function automatic logic [19:0] bcd_inc20(input logic [19:0] v);
        logic [19:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [19:0] bcd_dec20(input logic [19:0] v);
        logic [19:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (borrow) begin
                if (r[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/menu_ctrl_btn_debounce.sv
// Synchronise, debounce and pulse-ify one raw push-button, with optional
// auto-repeat while the accepted level stays high.
module btn_debounce #(
    parameter logic [15:0] DEB_CNT   = 16'd50000,
    parameter logic [23:0] RPT_CNT   = 24'd5000000,
    parameter bit          REPEAT_EN = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    logic [1:0]  sync_reg;
    logic        level_reg;
    logic [15:0] deb_cnt_reg;
    logic [23:0] rpt_cnt_reg;
    logic        press_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_reg    <= 2'b00;
            level_reg   <= 1'b0;
            deb_cnt_reg <= 16'd0;
            rpt_cnt_reg <= 24'd0;
            press_reg   <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], raw};
            press_reg <= 1'b0;
            if (sync_reg[1] == level_reg) begin
                deb_cnt_reg <= 16'd0;
                if (REPEAT_EN && level_reg) begin
                    if (rpt_cnt_reg == RPT_CNT - 24'd1) begin
                        rpt_cnt_reg <= 24'd0;
                        press_reg   <= 1'b1;
                    end else begin
                        rpt_cnt_reg <= rpt_cnt_reg + 24'd1;
                    end
                end else begin
                    rpt_cnt_reg <= 24'd0;
                end
            end else begin
                // Any disagreement restarts the repeat interval, so a release
                // in progress can never emit a late repeat pulse.
                rpt_cnt_reg <= 24'd0;
                if (deb_cnt_reg == DEB_CNT - 16'd1) begin
                    deb_cnt_reg <= 16'd0;
                    level_reg   <= sync_reg[1];
                    press_reg   <= sync_reg[1];
                end else begin
                    deb_cnt_reg <= deb_cnt_reg + 16'd1;
                end
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/menu_ctrl.sv
// OSD menu producer: debounced buttons drive a navigate/edit/commit FSM over
// five BCD parameters; everything the renderer sees is latched on newframe.
module menu_ctrl
    import menu_ctrl_pkg::*;
#(
    parameter logic [15:0] DEB_CNT        = 16'd50000,
    parameter logic [23:0] RPT_CNT        = 24'd5000000,
    parameter logic [9:0]  TIMEOUT_FRAMES = 10'd600,
    parameter logic [19:0] MODE_MAX       = 20'h00003,
    parameter logic [19:0] AGC_MAX        = 20'h00002,
    parameter logic [19:0] LVL1_MAX       = 20'h65535,
    parameter logic [19:0] LVL2_MAX       = 20'h09999,
    parameter logic [19:0] TINT_MAX       = 20'h00100,
    parameter logic [19:0] DEF0           = 20'h00000,
    parameter logic [19:0] DEF1           = 20'h00000,
    parameter logic [19:0] DEF2           = 20'h00000,
    parameter logic [19:0] DEF3           = 20'h00000,
    parameter logic [19:0] DEF4           = 20'h00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        newframe,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_sel,
    output logic [19:0] out_mode,
    output logic [19:0] out_Type_AGC,
    output logic [19:0] out_Set_LVL1,
    output logic [19:0] out_Set_LVL2,
    output logic [19:0] out_Time_int,
    output logic [2:0]  cursor,
    output logic        edit_active,
    output logic        menu_visible
);

    localparam logic [NUM_ITEMS-1:0][19:0] DEF_TAB = {DEF4, DEF3, DEF2, DEF1, DEF0};

    logic [NUM_BTNS-1:0] raw_vec;
    logic [NUM_BTNS-1:0] press_vec;

    assign raw_vec = {btn_sel, btn_down, btn_up};

    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
        btn_debounce #(
            .DEB_CNT   (DEB_CNT),
            .RPT_CNT   (RPT_CNT),
            .REPEAT_EN (gi != BTN_SEL)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw_vec[gi]),
            .press (press_vec[gi])
        );
    end

    logic sel_evt, up_evt, down_evt, any_press;

    // Select wins outright; up and down together cancel each other.
    assign sel_evt   = press_vec[BTN_SEL];
    assign up_evt    = press_vec[BTN_UP]   & ~press_vec[BTN_DOWN] & ~press_vec[BTN_SEL];
    assign down_evt  = press_vec[BTN_DOWN] & ~press_vec[BTN_UP]   & ~press_vec[BTN_SEL];
    assign any_press = |press_vec;

    state_t                      state_reg;
    logic [2:0]                  cursor_reg;
    logic [19:0]                 working_reg;
    logic [NUM_ITEMS-1:0][19:0]  item_reg;
    logic [9:0]                  frame_cnt_reg;
    logic [19:0]                 cur_max;

    always_comb begin
        cur_max = 20'h00000;
        case (cursor_reg)
            3'd0:    cur_max = MODE_MAX;
            3'd1:    cur_max = AGC_MAX;
            3'd2:    cur_max = LVL1_MAX;
            3'd3:    cur_max = LVL2_MAX;
            3'd4:    cur_max = TINT_MAX;
            default: cur_max = 20'h00000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= ST_HIDDEN;
            cursor_reg    <= 3'd0;
            working_reg   <= DEF_TAB[0];
            frame_cnt_reg <= 10'd0;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                item_reg[i] <= DEF_TAB[i];
            end
        end else begin
            case (state_reg)
                ST_HIDDEN: begin
                    if (sel_evt) begin
                        state_reg <= ST_NAV;
                    end
                end
                ST_NAV: begin
                    if (sel_evt) begin
                        working_reg <= item_reg[cursor_reg];
                        state_reg   <= ST_EDIT;
                    end else if (up_evt) begin
                        cursor_reg <= (cursor_reg == 3'd4) ? 3'd0 : cursor_reg + 3'd1;
                    end else if (down_evt) begin
                        cursor_reg <= (cursor_reg == 3'd0) ? 3'd4 : cursor_reg - 3'd1;
                    end
                end
                ST_EDIT: begin
                    if (sel_evt) begin
                        state_reg <= ST_COMMIT;
                    end else if (up_evt && (working_reg < cur_max)) begin
                        working_reg <= bcd_inc20(working_reg);
                    end else if (down_evt && (working_reg != 20'h00000)) begin
                        working_reg <= bcd_dec20(working_reg);
                    end
                end
                ST_COMMIT: begin
                    item_reg[cursor_reg] <= working_reg;
                    state_reg            <= ST_NAV;
                end
                default: state_reg <= ST_HIDDEN;
            endcase

            // Inactivity timeout; only reachable on cycles with no press, so it
            // never collides with a transition taken above.
            if (any_press) begin
                frame_cnt_reg <= 10'd0;
            end else if (newframe && (state_reg == ST_NAV || state_reg == ST_EDIT)) begin
                if (frame_cnt_reg == TIMEOUT_FRAMES - 10'd1) begin
                    frame_cnt_reg <= 10'd0;
                    state_reg     <= ST_HIDDEN;
                end else begin
                    frame_cnt_reg <= frame_cnt_reg + 10'd1;
                end
            end
        end
    end

    logic [19:0] disp_val [NUM_ITEMS];

    for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_disp
        logic [19:0] val_reg;

        always_ff @(posedge clk) begin
            if (!rst) begin
                val_reg <= DEF_TAB[gi];
            end else if (newframe) begin
                val_reg <= (state_reg == ST_EDIT && cursor_reg == 3'(gi)) ? working_reg
                                                                           : item_reg[gi];
            end
        end

        assign disp_val[gi] = val_reg;
    end

    logic [2:0] disp_cursor_reg;
    logic       edit_active_reg;
    logic       menu_visible_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            disp_cursor_reg  <= 3'd0;
            edit_active_reg  <= 1'b0;
            menu_visible_reg <= 1'b0;
        end else if (newframe) begin
            disp_cursor_reg  <= cursor_reg;
            edit_active_reg  <= (state_reg == ST_EDIT);
            menu_visible_reg <= (state_reg != ST_HIDDEN);
        end
    end

    assign out_mode     = disp_val[ITEM_MODE];
    assign out_Type_AGC = disp_val[ITEM_AGC];
    assign out_Set_LVL1 = disp_val[ITEM_LVL1];
    assign out_Set_LVL2 = disp_val[ITEM_LVL2];
    assign out_Time_int = disp_val[ITEM_TINT];
    assign cursor       = disp_cursor_reg;
    assign edit_active  = edit_active_reg;
    assign menu_visible = menu_visible_reg;

endmodule

// File: tb/tb_menu_ctrl.sv
// Drives button sequences into menu_ctrl and checks each frame-latched
// snapshot against a decimal-arithmetic model of the menu.
module tb_menu_ctrl;

    localparam int B_UP  = 0;
    localparam int B_DN  = 1;
    localparam int B_SEL = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        newframe = 1'b0;
    logic [2:0]  raw_btn = 3'b000;
    logic [19:0] o_mode, o_agc, o_lvl1, o_lvl2, o_tint;
    logic [2:0]  o_cursor;
    logic        o_edit, o_vis;

    menu_ctrl #(
        .DEB_CNT        (16'd4),
        .RPT_CNT        (24'd20),
        .TIMEOUT_FRAMES (10'd3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .newframe     (newframe),
        .btn_up       (raw_btn[B_UP]),
        .btn_down     (raw_btn[B_DN]),
        .btn_sel      (raw_btn[B_SEL]),
        .out_mode     (o_mode),
        .out_Type_AGC (o_agc),
        .out_Set_LVL1 (o_lvl1),
        .out_Set_LVL2 (o_lvl2),
        .out_Time_int (o_tint),
        .cursor       (o_cursor),
        .edit_active  (o_edit),
        .menu_visible (o_vis)
    );

    always #5 clk = ~clk;

    int fr_cnt = 0;
    initial begin
        forever begin
            @(negedge clk);
            fr_cnt++;
            newframe = (fr_cnt % 50 == 0);
        end
    end

    typedef struct {
        string                 name;
        logic [4:0][19:0]      outs;
        logic [2:0]            cur;
        bit                    care_cur;
        bit                    edit;
        bit                    vis;
    } snap_t;

    snap_t q[$];
    int    tests = 0;
    int    fails = 0;

    // Model: menu held as plain decimal integers
    int MAXD [5] = '{3, 2, 65535, 9999, 100};
    int m_item [5];
    int m_work;
    int m_cur;
    int m_st;  // 0 hidden, 1 navigating, 2 editing

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int t;
        t = v;
        for (int i = 0; i < 5; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) m_item[i] = 0;
        m_work = 0;
        m_cur  = 0;
        m_st   = 0;
    endtask

    task automatic apply(input int b, input int k);
        case (b)
            B_SEL: begin
                if (m_st == 0) m_st = 1;
                else if (m_st == 1) begin m_work = m_item[m_cur]; m_st = 2; end
                else begin m_item[m_cur] = m_work; m_st = 1; end
            end
            B_UP: begin
                if (m_st == 1) m_cur = (m_cur + k) % 5;
                else if (m_st == 2) m_work = (m_work + k > MAXD[m_cur]) ? MAXD[m_cur] : m_work + k;
            end
            default: begin
                if (m_st == 1) m_cur = ((m_cur - k) % 5 + 5) % 5;
                else if (m_st == 2) m_work = (m_work - k < 0) ? 0 : m_work - k;
            end
        endcase
    endtask

    // Hold one button for n sampled clocks; a held up/down yields one press
    // after the debounce delay and one more every repeat interval.
    task automatic btn(input int b, input int n);
        int k;
        @(negedge clk);
        raw_btn[b] = 1'b1;
        repeat (n) @(negedge clk);
        raw_btn[b] = 1'b0;
        repeat (12) @(negedge clk);
        k = (b == B_SEL) ? 1 : ((n < 6) ? 0 : 1 + (n - 6) / 20);
        apply(b, k);
    endtask

    task automatic raw_only(input logic [2:0] mask, input int n);
        @(negedge clk);
        raw_btn = mask;
        repeat (n) @(negedge clk);
        raw_btn = 3'b000;
        repeat (12) @(negedge clk);
    endtask

    task automatic goto_item(input int t);
        for (int i = 0; i < 5 && m_cur != t; i++) btn(B_UP, 10);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d snapshots pending, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic push_snap(input string name, input bit care_cur);
        snap_t s;
        s.name = name;
        for (int i = 0; i < 5; i++)
            s.outs[i] = to_bcd((m_st == 2 && i == m_cur) ? m_work : m_item[i]);
        s.cur      = 3'(m_cur);
        s.care_cur = care_cur;
        s.edit     = (m_st == 2);
        s.vis      = (m_st != 0);
        q.push_back(s);
        wait_drain();
    endtask

    task automatic check(input snap_t e);
        logic [4:0][19:0] got;
        got = {o_tint, o_lvl2, o_lvl1, o_agc, o_mode};
        $display("[TB] %s: outs %h %h %h %h %h cur %0d edit %0d vis %0d",
                 e.name, got[0], got[1], got[2], got[3], got[4], o_cursor, o_edit, o_vis);
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (got[i] !== e.outs[i]) begin
                fails++;
                $display("FAIL %s out[%0d]: got %h want %h", e.name, i, got[i], e.outs[i]);
            end
        end
        if (e.care_cur) begin
            tests++;
            if (o_cursor !== e.cur) begin
                fails++;
                $display("FAIL %s cursor: got %0d want %0d", e.name, o_cursor, e.cur);
            end
        end
        tests++;
        if (o_edit !== e.edit) begin
            fails++;
            $display("FAIL %s edit_active: got %0d want %0d", e.name, o_edit, e.edit);
        end
        tests++;
        if (o_vis !== e.vis) begin
            fails++;
            $display("FAIL %s menu_visible: got %0d want %0d", e.name, o_vis, e.vis);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (newframe) begin
                #1;
                if (q.size() > 0) check(q.pop_front());
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        push_snap("reset", 1'b1);

        btn(B_SEL, 10);
        btn(B_DN, 10);
        push_snap("nav_wrap_down", 1'b1);
        btn(B_UP, 10);
        push_snap("nav_wrap_up", 1'b1);

        goto_item(2);
        btn(B_SEL, 10);
        btn(B_UP, 6 + 98 * 20);
        btn(B_SEL, 10);
        push_snap("lvl1_99", 1'b1);
        btn(B_SEL, 10);
        btn(B_UP, 10);
        push_snap("lvl1_carry_preview", 1'b1);
        btn(B_SEL, 10);
        push_snap("lvl1_commit", 1'b1);

        goto_item(1);
        btn(B_SEL, 10);
        btn(B_UP, 10);
        btn(B_UP, 10);
        btn(B_SEL, 10);
        push_snap("agc_at_max", 1'b1);
        btn(B_SEL, 10);
        for (int i = 0; i < 3; i++) btn(B_UP, 10);
        push_snap("agc_saturate", 1'b1);
        btn(B_SEL, 10);
        goto_item(0);
        btn(B_SEL, 10);
        btn(B_DN, 10);
        btn(B_DN, 10);
        push_snap("mode_floor", 1'b1);
        btn(B_SEL, 10);
        push_snap("mode_commit", 1'b1);

        goto_item(2);
        btn(B_SEL, 10);
        btn(B_UP, 10);
        raw_only(3'b011, 20);
        btn(B_DN, 10);
        raw_only(3'b001, 2);
        push_snap("glitch_and_both", 1'b1);
        btn(B_UP, 100);
        push_snap("repeat_100", 1'b1);
        btn(B_SEL, 10);

        for (int n = 0; n < 25; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) btn(B_SEL, 10);
            else if (m_st == 2) btn((r < 6) ? B_UP : B_DN, $urandom_range(10, 70));
            else btn((r < 6) ? B_UP : B_DN, 10);
            push_snap($sformatf("rand_%0d", n), 1'b1);
        end

        if (m_st == 2) btn(B_SEL, 10);
        goto_item(3);
        btn(B_SEL, 10);
        if (m_work > 0) btn(B_DN, 6 + 20 * m_work);
        btn(B_UP, 6 + 9 * 20);
        btn(B_SEL, 10);
        push_snap("lvl2_10", 1'b1);
        btn(B_SEL, 10);
        btn(B_UP, 10);
        btn(B_UP, 10);
        push_snap("lvl2_preview", 1'b1);
        repeat (250) @(negedge clk);
        m_st = 0;
        push_snap("timeout_hidden", 1'b0);

        btn(B_SEL, 10);
        btn(B_SEL, 10);
        btn(B_UP, 10);
        btn(B_UP, 10);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_reset();
        push_snap("reset_mid_edit", 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
